// File: rtl/mem_bus_bridge.sv
// Bridge from the core's single memory port to a req/ack memory bus with timeout.
// Optional single-entry read cache enabled by defining BRIDGE_RDCACHE_EN.
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cpu_access;
  logic          timed_out;
  logic          hit;
  logic [31:0]   hit_data;
  logic          unused_adr_lsbs;

  assign cpu_access      = cpu_we | cpu_re;
  assign timed_out       = (state == REQ) && !mem_ack && (cnt == CNT_LAST);
  assign cpu_stall       = ((state == IDLE) && cpu_access) || (state == REQ);
  assign unused_adr_lsbs = ^cpu_adr[1:0];

`ifdef BRIDGE_RDCACHE_EN
  logic [29:0] c_tag;
  logic [31:0] c_data;
  logic        c_valid;

  assign hit      = cpu_re && !cpu_we && c_valid && (c_tag == cpu_adr[31:2]);
  assign hit_data = c_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_tag   <= '0;
      c_data  <= '0;
      c_valid <= 1'b0;
    end else if (state == REQ) begin
      if (mem_ack) begin
        if (!mem_we) begin
          c_tag   <= mem_adr;
          c_data  <= mem_rdata;
          c_valid <= 1'b1;
        end else if (c_valid && (c_tag == mem_adr)) begin
          c_data  <= mem_wd;
        end
      end else if (timed_out) begin
        c_valid <= 1'b0;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_adr <= '0;
      mem_wd  <= '0;
      cpu_rd  <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_access) begin
            mem_adr <= cpu_adr[31:2];
            mem_wd  <= cpu_wd;
            mem_we  <= cpu_we;
            cnt     <= '0;
            // A cache hit completes without touching the bus.
            if (hit) begin
              cpu_rd <= hit_data;
              state  <= DONE;
            end else begin
              mem_req <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            if (!mem_we) cpu_rd <= mem_rdata;
            state   <= DONE;
          end else if (timed_out) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            bus_err <= 1'b1;
            if (!mem_we) cpu_rd <= ERR_DATA;
            state   <= ERR;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: transaction table plus reset and read-cache sequences.
// Expectations for the cache sequence follow whether BRIDGE_RDCACHE_EN is defined.
module tb_mem_bus_bridge;

  localparam int unsigned TO     = 8;
  localparam int unsigned NO_ACK = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_adr, cpu_wd, cpu_rd, mem_wd, mem_rdata;
  logic        cpu_we, cpu_re, cpu_stall, mem_req, mem_we, mem_ack, bus_err;
  logic [29:0] mem_adr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_bus_bridge #(.TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .cpu_adr(cpu_adr), .cpu_wd(cpu_wd), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, re;
    logic [31:0] adr, wd;
    int unsigned ack_at;     // REQ cycle index carrying mem_ack, NO_ACK for none
    logic [31:0] rdata;
    int unsigned exp_stall, exp_reqs;
    logic [31:0] exp_rd;
    logic [29:0] exp_adr;
    logic        exp_we, exp_err;
  } txn_t;

  txn_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input txn_t t, input string nm);
    int unsigned stalls = 0;
    int unsigned reqs   = 0;
    bit          fin    = 0;
    @(negedge clk);
    cpu_we = t.we; cpu_re = t.re; cpu_adr = t.adr; cpu_wd = t.wd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!cpu_stall && c > 0) begin
        fin = 1;
        cpu_we = 1'b0; cpu_re = 1'b0;
        break;
      end
      if (cpu_stall) stalls++;
      if (mem_req) begin
        if (reqs == 0) begin
          chk({nm, ".mem_adr"}, {2'b00, mem_adr}, {2'b00, t.exp_adr});
          chk({nm, ".mem_we"}, {31'd0, mem_we}, {31'd0, t.exp_we});
          if (t.exp_we) chk({nm, ".mem_wd"}, mem_wd, t.wd);
        end
        if (reqs == t.ack_at) begin
          mem_ack = 1'b1; mem_rdata = t.rdata;
        end
        reqs++;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk({nm, ".completed"}, {31'd0, fin}, 32'd1);
    chk({nm, ".stall_cycles"}, stalls, t.exp_stall);
    chk({nm, ".req_cycles"}, reqs, t.exp_reqs);
    chk({nm, ".cpu_rd"}, cpu_rd, t.exp_rd);
    chk({nm, ".bus_err"}, {31'd0, bus_err}, {31'd0, t.exp_err});
    chk({nm, ".mem_req_end"}, {31'd0, mem_req}, 32'd0);
  endtask

  function automatic txn_t mk(logic we, logic re, logic [31:0] adr, logic [31:0] wd,
                              int unsigned ack_at, logic [31:0] rdata, int unsigned st,
                              int unsigned rq, logic [31:0] rd, logic err);
    txn_t t;
    t.we = we; t.re = re; t.adr = adr; t.wd = wd; t.ack_at = ack_at; t.rdata = rdata;
    t.exp_stall = st; t.exp_reqs = rq; t.exp_rd = rd;
    t.exp_adr = adr[31:2]; t.exp_we = we; t.exp_err = err;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd2, rd4;
    //             we    re    adr           wd            ack     rdata         st rq exp_rd        err
    tbl[0] = mk(1'b0, 1'b1, 32'h0000_0047, 32'h0,        2,      32'h1234_5678, 4, 3, 32'h1234_5678, 1'b0);
    tbl[1] = mk(1'b1, 1'b0, 32'h0000_0060, 32'hCAFE_F00D, 0,     32'hFFFF_FFFF, 2, 1, 32'h1234_5678, 1'b0);
    tbl[2] = mk(1'b1, 1'b1, 32'h0000_0080, 32'h1111_2222, TO-1,  32'h9999_9999, 9, 8, 32'h1234_5678, 1'b0);
    tbl[3] = mk(1'b0, 1'b1, 32'h0000_0203, 32'h0,        1,      32'h0BAD_F00D, 3, 2, 32'h0BAD_F00D, 1'b0);
    tbl[4] = mk(1'b0, 1'b1, 32'h0000_0100, 32'h0,        NO_ACK, 32'h0,         9, 8, 32'hDEAD_BEEF, 1'b1);
    tbl[5] = mk(1'b0, 1'b1, 32'h0000_0104, 32'h0,        0,      32'h55AA_55AA, 2, 1, 32'h55AA_55AA, 1'b1);
    tbl[6] = mk(1'b1, 1'b0, 32'h0000_0108, 32'h7777_0000, NO_ACK, 32'h0,        9, 8, 32'h55AA_55AA, 1'b1);

    reset = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_adr = '0; cpu_wd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst.mem_adr", {2'b00, mem_adr}, 32'd0);
    chk("rst.mem_wd", mem_wd, 32'd0);
    chk("rst.cpu_rd", cpu_rd, 32'd0);
    chk("rst.bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst.stall", {31'd0, cpu_stall}, 32'd0);

    // Reset asserted mid-REQ drops mem_req at once; a later ack is ignored.
    reset = 1'b1;
    @(negedge clk); cpu_re = 1'b1; cpu_adr = 32'h44;
    @(negedge clk); #1;
    chk("midreq.mem_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b0; #1;
    chk("midreq.async_drop", {31'd0, mem_req}, 32'd0);
    cpu_re = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("postrst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("postrst.stall", {31'd0, cpu_stall}, 32'd0);
    chk("postrst.cpu_rd", cpu_rd, 32'd0);
    chk("postrst.bus_err", {31'd0, bus_err}, 32'd0);

    for (int i = 0; i < 7; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Sticky bus_err only clears on reset.
    @(negedge clk); #1;
    chk("sticky.bus_err", {31'd0, bus_err}, 32'd1);
    reset = 1'b0; #1;
    chk("rst2.bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // Repeated read, then write and read of the same word.
    do_txn(mk(1'b0, 1'b1, 32'h44, 32'h0, 1, 32'h7777_7777, 3, 2, 32'h7777_7777, 1'b0), "c.rd1");
`ifdef BRIDGE_RDCACHE_EN
    rd2 = 32'h7777_7777; rd4 = 32'hA5A5_A5A5;
    do_txn(mk(1'b0, 1'b1, 32'h44, 32'h0, 0, 32'h6666_6666, 1, 0, rd2, 1'b0), "c.rd2");
    do_txn(mk(1'b1, 1'b0, 32'h44, 32'hA5A5_A5A5, 0, 32'h0, 2, 1, rd2, 1'b0), "c.wr");
    do_txn(mk(1'b0, 1'b1, 32'h44, 32'h0, 0, 32'h1212_1212, 1, 0, rd4, 1'b0), "c.rd4");
`else
    rd2 = 32'h6666_6666; rd4 = 32'h1212_1212;
    do_txn(mk(1'b0, 1'b1, 32'h44, 32'h0, 0, 32'h6666_6666, 2, 1, rd2, 1'b0), "c.rd2");
    do_txn(mk(1'b1, 1'b0, 32'h44, 32'hA5A5_A5A5, 0, 32'h0, 2, 1, rd2, 1'b0), "c.wr");
    do_txn(mk(1'b0, 1'b1, 32'h44, 32'h0, 0, 32'h1212_1212, 2, 1, rd4, 1'b0), "c.rd4");
`endif
    do_txn(mk(1'b0, 1'b1, 32'h48, 32'h0, 0, 32'h3434_3434, 2, 1, 32'h3434_3434, 1'b0), "c.other");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
